// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter controller: streams a SRC_W x SRC_H sprite from a synchronous ROM into the
// framebuffer write port at a requested origin, clipping at the screen edge and skipping a key colour.
module sprite_blit_ctrl #(
    parameter int SRC_W = 64,
    parameter int SRC_H = 64,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int AW    = 19,
    parameter int SAW   = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [9:0]     x0,
    input  logic [8:0]     y0,
    input  logic           key_en,
    input  logic [7:0]     key,
    output logic           busy,
    output logic           done,
    output logic [SAW-1:0] s_addr,
    input  logic [7:0]     s_dout,
    output logic           we,
    output logic [AW-1:0]  addr,
    output logic [7:0]     dout
);

    localparam int IW = $clog2(SRC_H);
    localparam int JW = $clog2(SRC_W);
    localparam logic [10:0] SCR_W_C = 11'(SCR_W);
    localparam logic [9:0]  SCR_H_C = 10'(SCR_H);
    localparam logic [31:0] SCR_W_V = 32'(SCR_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   i;
    logic [JW-1:0]   j;
    logic [9:0]      x0_l;
    logic [8:0]      y0_l;
    logic            key_en_l;
    logic [7:0]      key_l;
    logic            valid_d;
    logic            inb_d;
    logic            origin_ok;
    logic            last_pix;
    logic            inb;
    logic [10:0]     col;
    logic [9:0]      row;
    logic [AW-1:0]   tgt;

    assign origin_ok = ({1'b0, x0} < SCR_W_C) && ({1'b0, y0} < SCR_H_C);
    assign last_pix  = (i == '1) && (j == '1);
    assign col       = {1'b0, x0_l} + 11'(j);
    assign row       = {1'b0, y0_l} + 10'(i);
    assign inb       = (col < SCR_W_C) && (row < SCR_H_C);

    // Row stride applied as a sum of shifted rows, one term per set bit of the screen width.
    always_comb begin
        tgt = AW'(col);
        for (int b = 0; b < 32; b++) begin
            if (SCR_W_V[b]) begin
                tgt = tgt + (AW'(row) << b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An off-screen request passes through FLUSH with nothing in flight, giving one busy cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = origin_ok ? RUN : FLUSH;
                end
            end
            RUN: begin
                if (last_pix) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i        <= '0;
            j        <= '0;
            x0_l     <= '0;
            y0_l     <= '0;
            key_en_l <= 1'b0;
            key_l    <= '0;
            valid_d  <= 1'b0;
            inb_d    <= 1'b0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_d <= 1'b0;
                    if (start && origin_ok) begin
                        x0_l     <= x0;
                        y0_l     <= y0;
                        key_en_l <= key_en;
                        key_l    <= key;
                        i        <= '0;
                        j        <= '0;
                    end
                end
                RUN: begin
                    valid_d <= 1'b1;
                    inb_d   <= inb;
                    // Clipped pixels leave the address bus holding the last on-screen target.
                    if (inb) begin
                        addr <= tgt;
                    end
                    j <= j + 1'b1;
                    if (j == '1) begin
                        i <= i + 1'b1;
                    end
                end
                default: begin
                    valid_d <= 1'b0;
                end
            endcase
        end
    end

    assign s_addr = SAW'({i, j});
    assign dout   = s_dout;
    assign we     = valid_d & inb_d & ~(key_en_l & (s_dout == key_l));
    assign busy   = (state == RUN) || (state == FLUSH);
    assign done   = (state == DONE);

endmodule
